// File: rtl/icache_dm_pkg.sv
// Shared types for the direct-mapped instruction cache.
package icache_dm_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module icache_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: zero-latency hits, multi-word line fill
// over a wait handshake, whole-cache flush and saturating hit/miss counters.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int NSETS = 16,
  parameter int WORDS = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             flush,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int OW    = $clog2(WORDS);
  localparam int IW    = $clog2(NSETS);
  localparam int TAG_W = 30 - OW - IW;
  localparam int CW    = (OW == 0) ? 1 : OW;
  localparam int AW    = OW + IW;

  icache_state_t    state, next_state;
  logic [NSETS-1:0] valid;
  logic [TAG_W-1:0] tag_mem [NSETS];
  word_t            data_mem [NSETS*WORDS];
  logic [31:0]      base;
  logic [CW-1:0]    cnt;

  logic [IW-1:0]    req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [AW-1:0]    req_addr, fill_addr;
  logic             hit, last, fill_write, fill_done, miss_start;

  // Index and word offset are contiguous, so they form the flat data-array address.
  assign req_idx   = IW'(imemaddr >> (2 + OW));
  assign req_tag   = TAG_W'(imemaddr >> (2 + OW + IW));
  assign req_addr  = AW'(imemaddr >> 2);
  assign fill_idx  = IW'(base >> (2 + OW));
  assign fill_tag  = TAG_W'(base >> (2 + OW + IW));
  assign fill_addr = AW'(base >> 2) | AW'(cnt);

  assign hit        = imemREN && valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last       = (cnt == CW'(WORDS - 1));
  assign fill_write = (state == FILL) && !iwait;
  assign fill_done  = fill_write && last;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    miss_start = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          ihit     = 1'b1;
          imemload = data_mem[req_addr];
        end else if (imemREN) begin
          miss_start = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = base + 32'({cnt, 2'b00});
        if (flush || fill_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= '0;
      cnt   <= '0;
      base  <= '0;
    end else begin
      if (miss_start) begin
        base <= imemaddr & ~32'(WORDS * 4 - 1);
        cnt  <= '0;
      end else if (fill_write && !last) begin
        cnt <= cnt + CW'(1);
      end
      // Flush beats a completing fill: the line must come out invalid.
      if (flush)          valid           <= '0;
      else if (fill_done) valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_write && !RST)           data_mem[fill_addr] <= iload;
    if (fill_done && !flush && !RST)  tag_mem[fill_idx]   <= fill_tag;
  end

  icache_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk  (CLK),
    .clr  (RST),
    .inc  (ihit),
    .count(hit_count)
  );

  icache_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk  (CLK),
    .clr  (RST),
    .inc  (miss_start),
    .count(miss_count)
  );

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm (NSETS=16, WORDS=2, CNT_W=4).
module tb_icache_dm;

  logic        CLK = 1'b0;
  logic        RST, imemREN, flush, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;
  logic [3:0]  hit_count, miss_count;

  int tests = 0;
  int fails = 0;

  icache_dm #(.NSETS(16), .WORDS(2), .CNT_W(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .flush     (flush),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Serves a two-word fill that has already begun; checks the request each cycle.
  task automatic serve_fill(input logic [31:0] fbase, input logic [31:0] d0,
                            input logic [31:0] d1, input int wt);
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w <= wt; w++) begin
        iwait = (w < wt);
        iload = (w < wt) ? 32'hDEAD_BEEF : ((k == 0) ? d0 : d1);
        #1;
        tests++;
        if (iREN !== 1'b1 || iaddr !== fbase + 32'(4 * k) || ihit !== 1'b0) begin
          fails++;
          $display("FAIL fill_req w%0d: iREN=%0b iaddr=%h ihit=%0b, expected iREN=1 iaddr=%h ihit=0",
                   k, iREN, iaddr, ihit, fbase + 32'(4 * k));
        end
        step();
      end
    end
    iwait = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1; flush = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
    step();
    step();
    RST = 1'b0; flush = 1'b0;
    #1;
    tests++;
    if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: ihit=%0b iREN=%0b iaddr=%h imemload=%h, expected all 0",
               ihit, iREN, iaddr, imemload);
    end
    tests++;
    if (hit_count !== 4'd0 || miss_count !== 4'd0) begin
      fails++;
      $display("FAIL reset_counters: hit=%0d miss=%0d, expected 0/0", hit_count, miss_count);
    end
  endtask

  task automatic test_cold_fill();
    imemREN = 1'b1; imemaddr = 32'h40;
    #1;
    tests++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin
      fails++;
      $display("FAIL cold_miss: ihit=%0b iREN=%0b, expected 0/0", ihit, iREN);
    end
    step();
    tests++;
    if (miss_count !== 4'd1) begin
      fails++;
      $display("FAIL cold_miss_count: got %0d expected 1", miss_count);
    end
    serve_fill(32'h40, 32'hAAAA_0000, 32'hAAAA_0001, 2);
    tests++;
    if (ihit !== 1'b1 || imemload !== 32'hAAAA_0000 || iREN !== 1'b0) begin
      fails++;
      $display("FAIL cold_retry_hit: ihit=%0b imemload=%h iREN=%0b, expected 1 AAAA0000 0",
               ihit, imemload, iREN);
    end
    step();
    tests++;
    if (hit_count !== 4'd1 || miss_count !== 4'd1) begin
      fails++;
      $display("FAIL cold_counts: hit=%0d miss=%0d, expected 1/1", hit_count, miss_count);
    end
  endtask

  task automatic test_hit();
    imemaddr = 32'h44;
    #1;
    tests++;
    if (ihit !== 1'b1 || imemload !== 32'hAAAA_0001 || iREN !== 1'b0) begin
      fails++;
      $display("FAIL hit_word1: ihit=%0b imemload=%h iREN=%0b, expected 1 AAAA0001 0",
               ihit, imemload, iREN);
    end
    step();
    tests++;
    if (hit_count !== 4'd2) begin
      fails++;
      $display("FAIL hit_count_inc: got %0d expected 2", hit_count);
    end
    imemREN = 1'b0;
    #1;
    tests++;
    if (ihit !== 1'b0 || imemload !== 32'h0) begin
      fails++;
      $display("FAIL no_req: ihit=%0b imemload=%h, expected 0 0", ihit, imemload);
    end
    step();
    tests++;
    if (hit_count !== 4'd2 || miss_count !== 4'd1) begin
      fails++;
      $display("FAIL no_req_counts: hit=%0d miss=%0d, expected 2/1", hit_count, miss_count);
    end
  endtask

  task automatic test_conflict();
    imemREN = 1'b1; imemaddr = 32'h440;
    #1;
    tests++;
    if (ihit !== 1'b0) begin
      fails++;
      $display("FAIL conflict_miss: ihit=%0b expected 0", ihit);
    end
    step();
    tests++;
    if (miss_count !== 4'd2) begin
      fails++;
      $display("FAIL conflict_miss_count: got %0d expected 2", miss_count);
    end
    // Request dropped and address changed while the fill runs.
    imemREN = 1'b0; imemaddr = 32'h0;
    serve_fill(32'h440, 32'hBBBB_0000, 32'hBBBB_0001, 1);
    imemREN = 1'b1; imemaddr = 32'h444;
    #1;
    tests++;
    if (ihit !== 1'b1 || imemload !== 32'hBBBB_0001) begin
      fails++;
      $display("FAIL conflict_hit: ihit=%0b imemload=%h, expected 1 BBBB0001", ihit, imemload);
    end
    step();
    imemaddr = 32'h40;
    #1;
    tests++;
    if (ihit !== 1'b0) begin
      fails++;
      $display("FAIL evicted_miss: ihit=%0b expected 0", ihit);
    end
    step();
    tests++;
    if (miss_count !== 4'd3 || hit_count !== 4'd3) begin
      fails++;
      $display("FAIL evicted_counts: hit=%0d miss=%0d, expected 3/3", hit_count, miss_count);
    end
    serve_fill(32'h40, 32'hAAAA_1000, 32'hAAAA_1001, 0);
    tests++;
    if (ihit !== 1'b1 || imemload !== 32'hAAAA_1000) begin
      fails++;
      $display("FAIL refill_hit: ihit=%0b imemload=%h, expected 1 AAAA1000", ihit, imemload);
    end
    step();
  endtask

  task automatic test_flush();
    imemaddr = 32'h80;
    step();
    tests++;
    if (miss_count !== 4'd4 || hit_count !== 4'd4) begin
      fails++;
      $display("FAIL flush_pre_counts: hit=%0d miss=%0d, expected 4/4", hit_count, miss_count);
    end
    iwait = 1'b0; iload = 32'hC0C0_0000;
    step();
    flush = 1'b1; iload = 32'hC0C0_0001;
    #1;
    tests++;
    if (iREN !== 1'b1 || iaddr !== 32'h84) begin
      fails++;
      $display("FAIL flush_last_word_req: iREN=%0b iaddr=%h, expected 1 00000084", iREN, iaddr);
    end
    step();
    flush = 1'b0; iwait = 1'b1;
    #1;
    tests++;
    if (iREN !== 1'b0 || ihit !== 1'b0) begin
      fails++;
      $display("FAIL flush_abort: iREN=%0b ihit=%0b, expected 0 0", iREN, ihit);
    end
    imemaddr = 32'h44;
    #1;
    tests++;
    if (ihit !== 1'b0) begin
      fails++;
      $display("FAIL flush_clears_all: ihit=%0b expected 0", ihit);
    end
    imemaddr = 32'h80;
    step();
    tests++;
    if (miss_count !== 4'd5) begin
      fails++;
      $display("FAIL flush_retry_miss: got %0d expected 5", miss_count);
    end
    serve_fill(32'h80, 32'hCCCC_0000, 32'hCCCC_0001, 0);
    tests++;
    if (ihit !== 1'b1 || imemload !== 32'hCCCC_0000) begin
      fails++;
      $display("FAIL flush_refill_hit: ihit=%0b imemload=%h, expected 1 CCCC0000", ihit, imemload);
    end
    step();
    imemaddr = 32'h84; flush = 1'b1;
    #1;
    tests++;
    if (ihit !== 1'b1 || imemload !== 32'hCCCC_0001) begin
      fails++;
      $display("FAIL flush_same_cycle_hit: ihit=%0b imemload=%h, expected 1 CCCC0001", ihit, imemload);
    end
    step();
    flush = 1'b0;
    #1;
    tests++;
    if (ihit !== 1'b0 || hit_count !== 4'd6 || miss_count !== 4'd5) begin
      fails++;
      $display("FAIL flush_after: ihit=%0b hit=%0d miss=%0d, expected 0 6 5", ihit, hit_count, miss_count);
    end
  endtask

  task automatic test_reset_midfill();
    step();
    iwait = 1'b0; iload = 32'h1234_5678;
    #1;
    tests++;
    if (iREN !== 1'b1 || iaddr !== 32'h80) begin
      fails++;
      $display("FAIL midfill_req: iREN=%0b iaddr=%h, expected 1 00000080", iREN, iaddr);
    end
    step();
    iwait = 1'b1; RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    tests++;
    if (iREN !== 1'b0 || ihit !== 1'b0 || iaddr !== 32'h0) begin
      fails++;
      $display("FAIL midfill_reset_outputs: iREN=%0b ihit=%0b iaddr=%h, expected 0 0 0", iREN, ihit, iaddr);
    end
    tests++;
    if (hit_count !== 4'd0 || miss_count !== 4'd0) begin
      fails++;
      $display("FAIL midfill_reset_counts: hit=%0d miss=%0d, expected 0/0", hit_count, miss_count);
    end
    step();
    tests++;
    if (miss_count !== 4'd1) begin
      fails++;
      $display("FAIL post_reset_miss: got %0d expected 1", miss_count);
    end
  endtask

  task automatic test_saturation();
    serve_fill(32'h80, 32'hEEEE_0000, 32'hEEEE_0001, 0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) begin
        tests++;
        if (hit_count !== 4'd14) begin
          fails++;
          $display("FAIL sat_midway: got %0d expected 14", hit_count);
        end
      end
    end
    #1;
    tests++;
    if (hit_count !== 4'd15 || ihit !== 1'b1 || imemload !== 32'hEEEE_0001) begin
      fails++;
      $display("FAIL sat_hold: hit=%0d ihit=%0b imemload=%h, expected 15 1 EEEE0001",
               hit_count, ihit, imemload);
    end
    tests++;
    if (miss_count !== 4'd1) begin
      fails++;
      $display("FAIL sat_miss_unchanged: got %0d expected 1", miss_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; flush = 1'b0; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
    test_reset();
    test_cold_fill();
    test_hit();
    test_conflict();
    test_flush();
    test_reset_midfill();
    imemaddr = 32'h84;
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
